fpmul_cu: RTL and testbench

Control unit for the single-precision floating-point multiplier. A one-hot-free, binary-encoded FSM that sequences the multiplier datapath through operand load, special-case dispatch, multiply, bias, normalise, round, range check and result write. It consumes the datapath status flags and produces every datapath load, select, set and reset strobe, plus a Go/Done handshake to the requester.

---
 rtl/fpmul_cu.sv | 147 ++++++++++++++
 tb/tb_fpmul_cu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_cu.sv
// Sequencer for the single-precision multiplier datapath: operand load, special-case
// dispatch, multiply/bias/normalise/round, range check, result write. Build option: FPMUL_DNF_FLUSH_EN.
`timescale 1ns/1ps
module fpmul_cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       Go,
    input  logic       Op_NaN,
    input  logic       Op_Inf,
    input  logic       Op_Zero,
    input  logic       MPH23,
    input  logic       Round,
    input  logic       Carry,
    input  logic       UFlow,
    input  logic       OFlow,
    input  logic       Dnf,
    output logic       SA_LD,
    output logic       EA_LD,
    output logic       MA_LD,
    output logic       SB_LD,
    output logic       EB_LD,
    output logic       MB_LD,
    output logic       SP_LD,
    output logic       EP_RST,
    output logic       EP_SET,
    output logic       EP_LD,
    output logic [1:0] EP_SEL,
    output logic       MPH_RST,
    output logic       MPH_SET,
    output logic       MPH_LD,
    output logic [2:0] MPH_SEL,
    output logic       MPL_SEL,
    output logic       MPL_LD,
    output logic       UF_RST,
    output logic       UF_LD,
    output logic       OF_RST,
    output logic       OF_LD,
    output logic       P_RST,
    output logic       P_LD,
    output logic       Done,
    output logic       Busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WAIT, S_DISP, S_MUL, S_BIAS, S_NORM, S_ROUND,
        S_CHECK, S_NAN, S_INF, S_ZERO, S_UFL, S_OFL, S_OUT, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_dnf_flush;

`ifdef FPMUL_DNF_FLUSH_EN
    assign w_dnf_flush = Dnf;
`else
    logic  w_unused_dnf;
    assign w_unused_dnf = Dnf;
    assign w_dnf_flush  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        SA_LD   = 1'b0;  EA_LD   = 1'b0;  MA_LD   = 1'b0;
        SB_LD   = 1'b0;  EB_LD   = 1'b0;  MB_LD   = 1'b0;
        SP_LD   = 1'b0;
        EP_RST  = 1'b0;  EP_SET  = 1'b0;  EP_LD   = 1'b0;  EP_SEL  = 2'b00;
        MPH_RST = 1'b0;  MPH_SET = 1'b0;  MPH_LD  = 1'b0;  MPH_SEL = 3'b000;
        MPL_SEL = 1'b0;  MPL_LD  = 1'b0;
        UF_RST  = 1'b0;  UF_LD   = 1'b0;  OF_RST  = 1'b0;  OF_LD   = 1'b0;
        P_RST   = 1'b0;  P_LD    = 1'b0;
        Done    = 1'b0;
        case (r_state)
            S_IDLE:  if (Go) w_next = S_LOAD;
            S_LOAD: begin
                SA_LD = 1'b1; EA_LD = 1'b1; MA_LD = 1'b1;
                SB_LD = 1'b1; EB_LD = 1'b1; MB_LD = 1'b1;
                UF_RST = 1'b1; OF_RST = 1'b1;
                w_next = S_WAIT;
            end
            // operand class flags become valid while we sit here
            S_WAIT:  w_next = S_DISP;
            S_DISP: begin
                SP_LD = 1'b1;
                if      (Op_NaN)                 w_next = S_NAN;
                else if (Op_Inf)                 w_next = S_INF;
                else if (Op_Zero || w_dnf_flush) w_next = S_ZERO;
                else                             w_next = S_MUL;
            end
            S_MUL: begin
                EP_LD  = 1'b1; EP_SEL  = 2'b00;
                MPH_LD = 1'b1; MPH_SEL = 3'b000;
                MPL_LD = 1'b1; MPL_SEL = 1'b0;
                w_next = S_BIAS;
            end
            S_BIAS: begin
                EP_LD = 1'b1; EP_SEL = 2'b10;
                w_next = S_NORM;
            end
            S_NORM: begin
                if (MPH23) begin
                    EP_LD = 1'b1; EP_SEL = 2'b01;
                end else begin
                    MPH_LD = 1'b1; MPH_SEL = 3'b001;
                    MPL_LD = 1'b1; MPL_SEL = 1'b1;
                end
                w_next = S_ROUND;
            end
            // a round carry out of the mantissa re-normalises to 1.0 and bumps the exponent
            S_ROUND: begin
                if (Round && Carry) begin
                    MPH_LD = 1'b1; MPH_SEL = 3'b100;
                    EP_LD  = 1'b1; EP_SEL  = 2'b01;
                end else if (Round) begin
                    MPH_LD = 1'b1; MPH_SEL = 3'b010;
                end
                w_next = S_CHECK;
            end
            S_CHECK: begin
                if      (UFlow) w_next = S_UFL;
                else if (OFlow) w_next = S_OFL;
                else            w_next = S_OUT;
            end
            S_NAN:  begin EP_SET = 1'b1; MPH_SET = 1'b1; w_next = S_OUT; end
            S_INF:  begin EP_SET = 1'b1; MPH_RST = 1'b1; w_next = S_OUT; end
            S_ZERO: begin EP_RST = 1'b1; MPH_RST = 1'b1; w_next = S_OUT; end
            S_UFL:  begin UF_LD = 1'b1; EP_RST = 1'b1; MPH_RST = 1'b1; w_next = S_OUT; end
            S_OFL:  begin OF_LD = 1'b1; EP_SET = 1'b1; MPH_RST = 1'b1; w_next = S_OUT; end
            S_OUT:  begin P_LD = 1'b1; w_next = S_DONE; end
            S_DONE: begin Done = 1'b1; w_next = S_IDLE; end
            default: w_next = S_IDLE;
        endcase
        Busy = (r_state != S_IDLE);
        // hold the datapath cleared for as long as reset is applied
        if (rst) begin
            {SA_LD, EA_LD, MA_LD, SB_LD, EB_LD, MB_LD, SP_LD} = '0;
            {EP_SET, EP_LD, EP_SEL, MPH_SET, MPH_LD, MPH_SEL} = '0;
            {MPL_SEL, MPL_LD, UF_LD, OF_LD, P_LD, Done, Busy} = '0;
            {EP_RST, MPH_RST, UF_RST, OF_RST, P_RST}          = '1;
        end
    end

endmodule

// File: tb/tb_fpmul_cu.sv
// Scoreboard bench for fpmul_cu: each operation pushes an expected strobe signature,
// a monitor accumulates the DUT strobes while Busy and compares on Done.
`timescale 1ns/1ps
module tb_fpmul_cu;

    logic clk = 1'b0;
    logic rst, Go;
    logic Op_NaN, Op_Inf, Op_Zero, MPH23, Round, Carry, UFlow, OFlow, Dnf;
    logic SA_LD, EA_LD, MA_LD, SB_LD, EB_LD, MB_LD, SP_LD;
    logic EP_RST, EP_SET, EP_LD;
    logic [1:0] EP_SEL;
    logic MPH_RST, MPH_SET, MPH_LD;
    logic [2:0] MPH_SEL;
    logic MPL_SEL, MPL_LD, UF_RST, UF_LD, OF_RST, OF_LD, P_RST, P_LD, Done, Busy;

    always #5 clk = ~clk;

    fpmul_cu dut (
        .clk(clk), .rst(rst), .Go(Go),
        .Op_NaN(Op_NaN), .Op_Inf(Op_Inf), .Op_Zero(Op_Zero),
        .MPH23(MPH23), .Round(Round), .Carry(Carry), .UFlow(UFlow), .OFlow(OFlow), .Dnf(Dnf),
        .SA_LD(SA_LD), .EA_LD(EA_LD), .MA_LD(MA_LD), .SB_LD(SB_LD), .EB_LD(EB_LD), .MB_LD(MB_LD),
        .SP_LD(SP_LD), .EP_RST(EP_RST), .EP_SET(EP_SET), .EP_LD(EP_LD), .EP_SEL(EP_SEL),
        .MPH_RST(MPH_RST), .MPH_SET(MPH_SET), .MPH_LD(MPH_LD), .MPH_SEL(MPH_SEL),
        .MPL_SEL(MPL_SEL), .MPL_LD(MPL_LD), .UF_RST(UF_RST), .UF_LD(UF_LD),
        .OF_RST(OF_RST), .OF_LD(OF_LD), .P_RST(P_RST), .P_LD(P_LD), .Done(Done), .Busy(Busy)
    );

    typedef struct packed {
        logic [7:0] busy;  // cycles with Busy high, = latency + 1
        logic [3:0] opld;  // total operand-load strobes
        logic [3:0] nsp;
        logic [3:0] nep;
        logic [3:0] epm;   // bit n set: EP_LD seen with EP_SEL==n
        logic [3:0] nmph;
        logic [7:0] mphm;
        logic [3:0] nmpl;
        logic [3:0] mplm;
        logic [7:0] flg;   // {EP_RST,EP_SET,MPH_RST,MPH_SET,UF_RST,OF_RST,UF_LD,OF_LD}
        logic [3:0] np;
    } sig_t;

    localparam logic [7:0] F_EPR = 8'h80, F_EPS = 8'h40, F_MPHR = 8'h20, F_MPHS = 8'h10;
    localparam logic [7:0] F_BASE = 8'h0C, F_UFL = 8'h02, F_OFL = 8'h01;

    int n_tests = 0;
    int n_fail  = 0;
    sig_t  exp_q[$];
    string name_q[$];
    sig_t  acc;

    function automatic sig_t mk(input int busy, input int nep, input logic [3:0] epm,
                                input int nmph, input logic [7:0] mphm,
                                input int nmpl, input logic [3:0] mplm, input logic [7:0] flg);
        sig_t s;
        s.busy = 8'(busy); s.opld = 4'd6; s.nsp = 4'd1;
        s.nep = 4'(nep);   s.epm = epm;
        s.nmph = 4'(nmph); s.mphm = mphm;
        s.nmpl = 4'(nmpl); s.mplm = mplm;
        s.flg = flg;       s.np = 4'd1;
        return s;
    endfunction

    // monitor
    always @(negedge clk) begin
        if (rst) begin
            acc = '0;
        end else if (Busy) begin
            acc.busy = acc.busy + 8'd1;
            acc.opld = acc.opld + 4'(SA_LD) + 4'(EA_LD) + 4'(MA_LD)
                                + 4'(SB_LD) + 4'(EB_LD) + 4'(MB_LD);
            if (SP_LD) acc.nsp = acc.nsp + 4'd1;
            if (EP_LD)  begin acc.nep  = acc.nep  + 4'd1; acc.epm[EP_SEL]   = 1'b1; end
            if (MPH_LD) begin acc.nmph = acc.nmph + 4'd1; acc.mphm[MPH_SEL] = 1'b1; end
            if (MPL_LD) begin acc.nmpl = acc.nmpl + 4'd1; acc.mplm[MPL_SEL] = 1'b1; end
            acc.flg = acc.flg | {EP_RST, EP_SET, MPH_RST, MPH_SET, UF_RST, OF_RST, UF_LD, OF_LD};
            if (P_LD) acc.np = acc.np + 4'd1;
            if (Done) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got signature %h, none expected", acc);
                end else begin
                    sig_t  e;
                    string nm;
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (acc !== e) begin
                        n_fail++;
                        $display("FAIL %s: got %h want %h", nm, acc, e);
                    end
                end
                acc = '0;
            end
        end else if (Done) begin
            n_tests++; n_fail++;
            $display("FAIL done_while_idle: Done=1 with Busy=0");
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic wait_done(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (Done) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got no Done want Done within 40 cycles", nm);
        end
    endtask

    // st = {Op_NaN,Op_Inf,Op_Zero,MPH23,Round,Carry,UFlow,OFlow,Dnf}
    task automatic do_op(input string nm, input logic [8:0] st, input sig_t e, input bit mid_go);
        @(posedge clk); #1;
        {Op_NaN, Op_Inf, Op_Zero, MPH23, Round, Carry, UFlow, OFlow, Dnf} = st;
        exp_q.push_back(e);
        name_q.push_back(nm);
        Go = 1'b1;
        @(posedge clk); #1;
        Go = 1'b0;
        if (mid_go) begin
            repeat (3) @(posedge clk);
            #1 Go = 1'b1;
            @(posedge clk); #1 Go = 1'b0;
        end
        wait_done(nm);
        @(posedge clk);
    endtask

    logic [4:0]  o_rst;
    logic [22:0] o_rest;
    assign o_rst  = {EP_RST, MPH_RST, UF_RST, OF_RST, P_RST};
    assign o_rest = {SA_LD, EA_LD, MA_LD, SB_LD, EB_LD, MB_LD, SP_LD, EP_SET, EP_LD, EP_SEL,
                     MPH_SET, MPH_LD, MPH_SEL, MPL_SEL, MPL_LD, UF_LD, OF_LD, P_LD, Done, Busy};

    sig_t s_norm0, s_norm1, s_rc, s_rnc, s_nan, s_inf, s_zero, s_ofl, s_ufl;

    initial begin
        // normal, MPH23=0, no round (2.0 x 3.0 = 6.0)
        s_norm0 = mk(10, 2, 4'b0101, 2, 8'h03, 2, 4'b0011, F_BASE);
        // normal, MPH23=1, no round (1.5 x 1.5 = 2.25)
        s_norm1 = mk(10, 3, 4'b0111, 1, 8'h01, 1, 4'b0001, F_BASE);
        s_rc    = mk(10, 3, 4'b0111, 3, 8'h13, 2, 4'b0011, F_BASE);
        s_rnc   = mk(10, 3, 4'b0111, 2, 8'h05, 1, 4'b0001, F_BASE);
        s_nan   = mk(6, 0, 4'b0, 0, 8'h0, 0, 4'b0, F_BASE | F_EPS | F_MPHS);
        s_inf   = mk(6, 0, 4'b0, 0, 8'h0, 0, 4'b0, F_BASE | F_EPS | F_MPHR);
        s_zero  = mk(6, 0, 4'b0, 0, 8'h0, 0, 4'b0, F_BASE | F_EPR | F_MPHR);
        s_ofl   = mk(11, 2, 4'b0101, 2, 8'h03, 2, 4'b0011, F_BASE | F_EPS | F_MPHR | F_OFL);
        s_ufl   = mk(11, 2, 4'b0101, 2, 8'h03, 2, 4'b0011, F_BASE | F_EPR | F_MPHR | F_UFL);

        rst = 1'b1; Go = 1'b0;
        {Op_NaN, Op_Inf, Op_Zero, MPH23, Round, Carry, UFlow, OFlow, Dnf} = '0;
        #12;
        chk("reset_rst_outs", 32'(o_rst), 32'h1F);
        chk("reset_other_outs", 32'(o_rest), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("idle_rst_outs", 32'(o_rst), 32'h0);
        chk("idle_other_outs", 32'(o_rest), 32'h0);

        do_op("mul_2x3",          9'b000_000_000, s_norm0, 1'b0);
        do_op("mul_1p5x1p5",      9'b000_100_000, s_norm1, 1'b0);
        do_op("carry_no_round",   9'b000_001_000, s_norm0, 1'b0);
        do_op("round_carry",      9'b000_011_000, s_rc,    1'b0);
        do_op("round_no_carry",   9'b000_110_000, s_rnc,   1'b0);
        do_op("nan_priority",     9'b111_000_000, s_nan,   1'b0);
        do_op("inf_x_zero_nan",   9'b101_000_000, s_nan,   1'b0);
        do_op("inf_over_zero",    9'b011_000_000, s_inf,   1'b0);
        do_op("zero",             9'b001_000_000, s_zero,  1'b0);
        do_op("overflow",         9'b000_000_010, s_ofl,   1'b0);
        do_op("uflow_beats_oflow",9'b000_000_110, s_ufl,   1'b0);
`ifdef FPMUL_DNF_FLUSH_EN
        do_op("dnf_flush",        9'b000_000_001, s_zero,  1'b0);
`else
        do_op("dnf_ignored",      9'b000_000_001, s_norm0, 1'b0);
`endif
        do_op("go_mid_op_ignored",9'b000_000_000, s_norm0, 1'b1);
        repeat (15) @(posedge clk);

        // abort in BIAS: Go sampled, then LOAD, WAIT, DISP, MUL, BIAS
        @(posedge clk); #1 Go = 1'b1;
        {Op_NaN, Op_Inf, Op_Zero, MPH23, Round, Carry, UFlow, OFlow, Dnf} = '0;
        @(posedge clk); #1 Go = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("abort_busy_done", {30'd0, Busy, Done}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        do_op("after_abort", 9'b000_000_000, s_norm0, 1'b0);

        // Go held high through DONE: FSM must pass through IDLE before restarting
        @(posedge clk); #1;
        exp_q.push_back(s_norm1); name_q.push_back("go_held_1");
        exp_q.push_back(s_norm1); name_q.push_back("go_held_2");
        MPH23 = 1'b1;
        Go = 1'b1;
        wait_done("go_held_1");
        @(negedge clk);
        chk("idle_after_done", {31'd0, Busy}, 32'h0);
        @(posedge clk); #1 Go = 1'b0;
        wait_done("go_held_2");

        repeat (15) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
